// File: rtl/mod_eq_pkg.sv
// Shared types and helpers for the mod-equality scheduler: FSM states,
// default constants and the modular accumulate step.
package mod_eq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MOD_DEFAULT    = 4;
  localparam int TARGET_DEFAULT = 1;

  // Wide enough for acc (< 16) plus a symbol (<= 3) without overflow.
  localparam int ACC_W = 5;

  function automatic logic [ACC_W-1:0] mod_add(
    input logic [ACC_W-1:0] acc,
    input logic [ACC_W-1:0] s,
    input logic [ACC_W-1:0] m
  );
    logic [ACC_W-1:0] sum;
    sum = acc + s;
    return (sum >= m) ? sum - m : sum;
  endfunction

endpackage

// File: rtl/mod_eq_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr,
// wrapping modulo NREQ. The pointer itself lives in the scheduler.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [IDW:0]   cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = '0;
    cand_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      cand_idx = cand[IDW-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mod_eq_sched.sv
// One shared residue accumulator (sum of 2A+B mod MOD) time-multiplexed
// between NREQ symbol streams under round-robin arbitration.
module mod_eq_sched
  import mod_eq_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int MOD    = MOD_DEFAULT,
  parameter int TARGET = TARGET_DEFAULT,
  parameter int IDW    = $clog2(NREQ),
  parameter int RW     = $clog2(MOD)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  input  logic [NREQ-1:0] req_last,
  output logic [NREQ-1:0] req_ready,
  output logic            res_valid,
  output logic [IDW-1:0]  res_id,
  output logic [RW-1:0]   res_residue,
  output logic            res_match,
  input  logic            res_ready,
  output logic            busy
);

  state_t         state, next_state;
  logic [IDW-1:0] grant, rr_ptr, arb_idx;
  logic           arb_found;
  logic [RW-1:0]  acc, new_acc;
  logic [1:0]     sym;
  logic           beat, last_beat;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (arb_found),
    .idx    (arb_idx)
  );

  always_comb begin
    next_state = state;
    req_ready  = '0;
    res_valid  = 1'b0;
    busy       = (state != IDLE);
    beat       = 1'b0;
    last_beat  = 1'b0;
    sym        = {req_a[grant], req_b[grant]};
    new_acc    = RW'(mod_add(ACC_W'(acc), ACC_W'(sym), ACC_W'(MOD)));
    case (state)
      IDLE: if (arb_found) next_state = BUSY;
      BUSY: begin
        req_ready[grant] = 1'b1;
        beat             = req_valid[grant];
        last_beat        = beat & req_last[grant];
        if (last_beat) next_state = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result fields are only written on the final beat, so they stay frozen
  // for the whole DONE phase regardless of how long the consumer stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      acc         <= '0;
      res_id      <= '0;
      res_residue <= '0;
      res_match   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && arb_found) begin
        grant <= arb_idx;
        acc   <= '0;
      end
      if (beat) acc <= new_acc;
      if (last_beat) begin
        res_residue <= new_acc;
        res_id      <= grant;
        res_match   <= (new_acc == RW'(TARGET));
      end
      if (state == DONE && res_ready)
        rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
    end
  end

endmodule
